// File: rtl/oc8051_cxrom_arb_pkg.sv
// Shared definitions for the oc8051 code-ROM arbiter: owner encoding and parameter defaults.
package oc8051_cxrom_arb_pkg;

  // One-hot so each rvalid output is a single flop bit of the owner register.
  typedef enum logic [2:0] {
    OWN_IDLE = 3'b001,
    OWN_CPU  = 3'b010,
    OWN_DMA  = 3'b100
  } owner_e;

  localparam int          STARVE_MAX_DEF = 4;
  localparam logic [15:0] DMA_LIMIT_DEF  = 16'h8000;

  function automatic logic dma_in_window(input logic [15:0] addr, input logic [15:0] limit);
    return (addr < limit);
  endfunction

endpackage

// File: rtl/oc8051_cxrom_arb_prio.sv
// Grant logic for the code-ROM arbiter: CPU-first priority with a DMA anti-starvation counter.
module oc8051_cxrom_prio
  import oc8051_cxrom_arb_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic cpu_req,
  input  logic dma_req,
  output logic cpu_gnt,
  output logic dma_gnt
);

  localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  logic [CW-1:0] starve_cnt_r;
  logic          starve_hit_s;

  assign starve_hit_s = (starve_cnt_r == CW'(STARVE_MAX));

  // grant decision; both grants held low during reset
  always_comb begin
    cpu_gnt = 1'b0;
    dma_gnt = 1'b0;
    if (!rst) begin
      cpu_gnt = 1'b0;
      dma_gnt = 1'b0;
    end else if (dma_req && (!cpu_req || starve_hit_s)) begin
      dma_gnt = 1'b1;
    end else if (cpu_req) begin
      cpu_gnt = 1'b1;
    end else begin
      cpu_gnt = 1'b0;
      dma_gnt = 1'b0;
    end
  end

  // count CPU wins while DMA waits; saturating
  always_ff @(posedge clk) begin
    if (!rst) begin
      starve_cnt_r <= {CW{1'b0}};
    end else if (dma_gnt || !dma_req) begin
      starve_cnt_r <= {CW{1'b0}};
    end else if (cpu_gnt && !starve_hit_s) begin
      starve_cnt_r <= starve_cnt_r + CW'(1);
    end else begin
      starve_cnt_r <= starve_cnt_r;
    end
  end

endmodule

// File: rtl/oc8051_cxrom_arb.sv
// Two-port (CPU fetch / boot-verify DMA) arbiter in front of the combinational oc8051 code ROM.
module oc8051_cxrom_arb
  import oc8051_cxrom_arb_pkg::*;
#(
  parameter int          STARVE_MAX = STARVE_MAX_DEF,
  parameter logic [15:0] DMA_LIMIT  = DMA_LIMIT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic [15:0] cpu_addr,
  output logic        cpu_gnt,
  output logic        cpu_rvalid,
  output logic [31:0] cpu_rdata,
  input  logic        dma_req,
  input  logic [15:0] dma_addr,
  output logic        dma_gnt,
  output logic        dma_rvalid,
  output logic [31:0] dma_rdata,
  output logic        dma_err,
  output logic [15:0] rom_addr,
  input  logic [31:0] rom_data
);

  owner_e      state_r;
  owner_e      state_s;
  logic [15:0] addr_r;

  oc8051_cxrom_prio #(.STARVE_MAX(STARVE_MAX)) u_prio (
    .clk     (clk),
    .rst     (rst),
    .cpu_req (cpu_req),
    .dma_req (dma_req),
    .cpu_gnt (cpu_gnt),
    .dma_gnt (dma_gnt)
  );

  // ROM address follows the winner, otherwise the last granted address
  always_comb begin
    rom_addr = addr_r;
    if (dma_gnt) begin
      rom_addr = dma_addr;
    end else if (cpu_gnt) begin
      rom_addr = cpu_addr;
    end else begin
      rom_addr = addr_r;
    end
  end

  // owner next state from this cycle's grant
  always_comb begin
    state_s = OWN_IDLE;
    if (dma_gnt) begin
      state_s = OWN_DMA;
    end else if (cpu_gnt) begin
      state_s = OWN_CPU;
    end else begin
      state_s = OWN_IDLE;
    end
  end

  // owner state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= OWN_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  assign cpu_rvalid = state_r[1];
  assign dma_rvalid = state_r[2];

  // return data, error flag and held address
  always_ff @(posedge clk) begin
    if (!rst) begin
      cpu_rdata <= 32'h0000_0000;
      dma_rdata <= 32'h0000_0000;
      dma_err   <= 1'b0;
      addr_r    <= 16'h0000;
    end else begin
      if (cpu_gnt) begin
        cpu_rdata <= rom_data;
      end
      if (dma_gnt) begin
        dma_rdata <= dma_in_window(dma_addr, DMA_LIMIT) ? rom_data : 32'h0000_0000;
        dma_err   <= !dma_in_window(dma_addr, DMA_LIMIT);
      end else begin
        dma_err   <= 1'b0;
      end
      if (cpu_gnt || dma_gnt) begin
        addr_r <= rom_addr;
      end
    end
  end

endmodule

// File: tb/tb_oc8051_cxrom_arb.sv
// Directed and constrained-random bench for oc8051_cxrom_arb with a behavioural ROM.
module tb_oc8051_cxrom_arb;

  localparam int SM = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req;
  logic [15:0] cpu_addr;
  logic        cpu_gnt;
  logic        cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        dma_req;
  logic [15:0] dma_addr;
  logic        dma_gnt;
  logic        dma_rvalid;
  logic [31:0] dma_rdata;
  logic        dma_err;
  logic [15:0] rom_addr;
  logic [31:0] rom_data;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_f(input logic [15:0] a);
    return {a ^ 16'hA5C3, ~a};
  endfunction

  assign rom_data = rom_f(rom_addr);

  oc8051_cxrom_arb #(.STARVE_MAX(SM), .DMA_LIMIT(16'h8000)) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_req    (cpu_req),
    .cpu_addr   (cpu_addr),
    .cpu_gnt    (cpu_gnt),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .dma_req    (dma_req),
    .dma_addr   (dma_addr),
    .dma_gnt    (dma_gnt),
    .dma_rvalid (dma_rvalid),
    .dma_rdata  (dma_rdata),
    .dma_err    (dma_err),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [9:0]  pat;
    logic [15:0] ea;
    logic        cg;
    logic        dg;
    logic [15:0] ca;
    logic [15:0] da;
    int          wait_c;

    // reset: grants forced low even with both requests up
    rst = 1'b0; cpu_req = 1'b1; cpu_addr = 16'h0055; dma_req = 1'b1; dma_addr = 16'h0066;
    #1;
    check("rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
    check("rst_dma_gnt", 32'(dma_gnt), 32'd0);
    tick(); tick();
    check("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
    check("rst_dma_rvalid", 32'(dma_rvalid), 32'd0);
    check("rst_dma_err", 32'(dma_err), 32'd0);
    check("rst_cpu_rdata", cpu_rdata, 32'd0);
    check("rst_dma_rdata", dma_rdata, 32'd0);
    check("rst_rom_addr", 32'(rom_addr), 32'd0);
    cpu_req = 1'b0; dma_req = 1'b0; rst = 1'b1;
    tick();
    check("idle_cpu_rvalid", 32'(cpu_rvalid), 32'd0);

    // single CPU fetch
    cpu_req = 1'b1; cpu_addr = 16'h0010;
    #1;
    check("cpu1_gnt", 32'(cpu_gnt), 32'd1);
    check("cpu1_dma_gnt", 32'(dma_gnt), 32'd0);
    check("cpu1_rom_addr", 32'(rom_addr), 32'h0010);
    tick();
    cpu_req = 1'b0;
    check("cpu1_rvalid", 32'(cpu_rvalid), 32'd1);
    check("cpu1_rdata", cpu_rdata, rom_f(16'h0010));
    check("cpu1_dma_rvalid", 32'(dma_rvalid), 32'd0);
    tick();
    check("cpu1_rvalid_drop", 32'(cpu_rvalid), 32'd0);
    check("cpu1_rdata_hold", cpu_rdata, rom_f(16'h0010));
    check("cpu1_rom_addr_hold", 32'(rom_addr), 32'h0010);

    // both ports saturated: C,C,C,C,D repeating
    pat = 10'b10_0001_0000;
    cpu_req = 1'b1; dma_req = 1'b1; cpu_addr = 16'h0100; dma_addr = 16'h0200;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("arb_dma_gnt", 32'(dma_gnt), 32'(pat[i]));
      check("arb_cpu_gnt", 32'(cpu_gnt), 32'(!pat[i]));
      ea = pat[i] ? dma_addr : cpu_addr;
      tick();
      if (pat[i]) begin
        check("arb_dma_rvalid", 32'(dma_rvalid), 32'd1);
        check("arb_dma_rdata", dma_rdata, rom_f(ea));
        check("arb_cpu_idle", 32'(cpu_rvalid), 32'd0);
        dma_addr = dma_addr + 16'd1;
      end else begin
        check("arb_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
        check("arb_cpu_rdata", cpu_rdata, rom_f(ea));
        check("arb_dma_idle", 32'(dma_rvalid), 32'd0);
        cpu_addr = cpu_addr + 16'd1;
      end
    end
    cpu_req = 1'b0; dma_req = 1'b0;
    tick();

    // DMA window boundary
    dma_req = 1'b1; dma_addr = 16'h8000;
    #1;
    check("win_gnt", 32'(dma_gnt), 32'd1);
    tick();
    check("win_oob_rvalid", 32'(dma_rvalid), 32'd1);
    check("win_oob_err", 32'(dma_err), 32'd1);
    check("win_oob_rdata", dma_rdata, 32'd0);
    dma_addr = 16'h7FFF;
    tick();
    check("win_in_rvalid", 32'(dma_rvalid), 32'd1);
    check("win_in_err", 32'(dma_err), 32'd0);
    check("win_in_rdata", dma_rdata, rom_f(16'h7FFF));
    dma_req = 1'b0;
    tick();
    check("win_rvalid_drop", 32'(dma_rvalid), 32'd0);
    check("win_err_drop", 32'(dma_err), 32'd0);
    check("win_rdata_hold", dma_rdata, rom_f(16'h7FFF));

    // DMA streaming, no bubbles
    dma_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      dma_addr = 16'(i);
      tick();
      check("stream_rvalid", 32'(dma_rvalid), 32'd1);
      check("stream_rdata", dma_rdata, rom_f(16'(i)));
    end
    dma_req = 1'b0;
    tick();
    check("stream_end", 32'(dma_rvalid), 32'd0);

    // reset right after a CPU grant
    cpu_req = 1'b1; cpu_addr = 16'h0033;
    tick();
    check("rstx_pre_rvalid", 32'(cpu_rvalid), 32'd1);
    check("rstx_pre_rdata", cpu_rdata, rom_f(16'h0033));
    rst = 1'b0;
    #1;
    check("rstx_gnt_low", 32'(cpu_gnt), 32'd0);
    tick();
    check("rstx_rvalid", 32'(cpu_rvalid), 32'd0);
    check("rstx_rdata", cpu_rdata, 32'd0);
    cpu_req = 1'b0; rst = 1'b1;
    tick();
    check("rstx_post_cpu", 32'(cpu_rvalid), 32'd0);
    check("rstx_post_dma", 32'(dma_rvalid), 32'd0);

    // random two-port traffic
    wait_c = 0;
    for (int i = 0; i < 300; i++) begin
      if (!cpu_req) begin
        cpu_req  = ($urandom_range(0, 3) != 0);
        cpu_addr = 16'($urandom);
      end
      if (!dma_req) begin
        dma_req  = ($urandom_range(0, 2) != 0);
        dma_addr = 16'($urandom);
        wait_c   = 0;
      end
      #1;
      cg = cpu_gnt; dg = dma_gnt; ca = cpu_addr; da = dma_addr;
      check("rnd_dual_gnt", 32'(cg && dg), 32'd0);
      check("rnd_cpu_gnt_noreq", 32'(cg && !cpu_req), 32'd0);
      check("rnd_dma_gnt_noreq", 32'(dg && !dma_req), 32'd0);
      if (dma_req && !dg) wait_c++;
      check("rnd_dma_wait", 32'(wait_c <= SM), 32'd1);
      tick();
      check("rnd_cpu_rvalid", 32'(cpu_rvalid), 32'(cg));
      check("rnd_dma_rvalid", 32'(dma_rvalid), 32'(dg));
      if (cg) check("rnd_cpu_rdata", cpu_rdata, rom_f(ca));
      if (dg) begin
        check("rnd_dma_rdata", dma_rdata, (da >= 16'h8000) ? 32'd0 : rom_f(da));
        check("rnd_dma_err", 32'(dma_err), 32'(da >= 16'h8000));
      end else begin
        check("rnd_dma_err_idle", 32'(dma_err), 32'd0);
      end
      if (cg) cpu_req = 1'b0;
      if (dg) dma_req = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
